// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads 3 bytes per instruction from a
// synchronous-read memory, classifies the opcode and hands it to decode.
module fetch_unit #(
   parameter int ADDR_W = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [23:0]       mem_data_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [7:0]        opcode_o,
   output logic [15:0]       operand_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic [1:0]        len_o,
   output logic              illegal_o
);

   localparam logic [7:0] OP_ORA_IMM   = 8'h09;
   localparam logic [7:0] OP_ORA_ZPG   = 8'h05;
   localparam logic [7:0] OP_ORA_ZPG_X = 8'h15;
   localparam logic [7:0] OP_AND_IMM   = 8'h29;
   localparam logic [7:0] OP_AND_ZPG   = 8'h25;
   localparam logic [7:0] OP_AND_ZPG_X = 8'h35;
   localparam logic [7:0] OP_EOR_IMM   = 8'h49;
   localparam logic [7:0] OP_EOR_ZPG   = 8'h45;
   localparam logic [7:0] OP_EOR_ZPG_X = 8'h55;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_RESP  = 2'd1,
      S_VALID = 2'd2
   } state_e;

   // Every supported opcode carries one operand byte, so all of them are 2 bytes long.
   function automatic logic is_supported(input logic [7:0] op);
      logic hit;
      hit = 1'b0;
      case (op)
         OP_ORA_IMM, OP_ORA_ZPG, OP_ORA_ZPG_X,
         OP_AND_IMM, OP_AND_ZPG, OP_AND_ZPG_X,
         OP_EOR_IMM, OP_EOR_ZPG, OP_EOR_ZPG_X: hit = 1'b1;
         default:                              hit = 1'b0;
      endcase
      return hit;
   endfunction

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              valid_q, valid_d;
   logic [7:0]        opcode_q, opcode_d;
   logic [15:0]       operand_q, operand_d;
   logic [ADDR_W-1:0] pc_out_q, pc_out_d;
   logic [1:0]        len_q, len_d;
   logic              illegal_q, illegal_d;
   logic              supported_s;

   assign supported_s = is_supported(mem_data_i[7:0]);

   // Next-state logic; redirect overrides every state, including a coincident handshake.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      valid_d   = valid_q;
      opcode_d  = opcode_q;
      operand_d = operand_q;
      pc_out_d  = pc_out_q;
      len_d     = len_q;
      illegal_d = illegal_q;
      if (redirect_i) begin
         state_d = S_REQ;
         pc_d    = redirect_pc_i;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            S_REQ: begin
               state_d = S_RESP;
            end
            S_RESP: begin
               opcode_d  = mem_data_i[7:0];
               operand_d = mem_data_i[23:8];
               pc_out_d  = pc_q;
               len_d     = supported_s ? 2'd2 : 2'd1;
               illegal_d = ~supported_s;
               valid_d   = 1'b1;
               state_d   = S_VALID;
            end
            S_VALID: begin
               if (ready_i) begin
                  pc_d    = pc_q + ADDR_W'(len_q);
                  valid_d = 1'b0;
                  state_d = S_REQ;
               end else begin
                  state_d = S_VALID;
               end
            end
            default: begin
               state_d = S_REQ;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers; reset clears valid_o without waiting for a clock.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= S_REQ;
         pc_q      <= RESET_PC;
         valid_q   <= 1'b0;
         opcode_q  <= 8'h00;
         operand_q <= 16'h0000;
         pc_out_q  <= {ADDR_W{1'b0}};
         len_q     <= 2'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         valid_q   <= valid_d;
         opcode_q  <= opcode_d;
         operand_q <= operand_d;
         pc_out_q  <= pc_out_d;
         len_q     <= len_d;
         illegal_q <= illegal_d;
      end
   end

   assign mem_addr_o = pc_q;
   assign valid_o    = valid_q;
   assign opcode_o   = opcode_q;
   assign operand_o  = operand_q;
   assign pc_o       = pc_out_q;
   assign len_o      = len_q;
   assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: transaction-level PC/instruction model plus
// a latency model, random ready/redirect traffic, and a 4-bit wrap-around check.
module tb_fetch_unit;

   typedef struct packed {
      logic [7:0]  op;
      logic [15:0] opr;
      logic [7:0]  pc;
      logic [1:0]  len;
      logic        ill;
   } exp_t;

   logic        clk;
   logic        rstn;
   logic [7:0]  mem_addr;
   logic [23:0] mem_data;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic        valid;
   logic        ready;
   logic [7:0]  opcode;
   logic [15:0] operand;
   logic [7:0]  pc;
   logic [1:0]  len;
   logic        illegal;

   logic [3:0]  mem_addr4;
   logic [23:0] mem_data4;
   logic        redirect4;
   logic [3:0]  redirect_pc4;
   logic        valid4;
   logic        ready4;
   logic [7:0]  opcode4;
   logic [15:0] operand4;
   logic [3:0]  pc4;
   logic [1:0]  len4;
   logic        illegal4;

   logic [7:0]  mem  [256];
   logic [7:0]  mem4 [16];

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q[$];

   fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk_i(clk), .rstn_i(rstn), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc), .valid_o(valid),
      .ready_i(ready), .opcode_o(opcode), .operand_o(operand), .pc_o(pc),
      .len_o(len), .illegal_o(illegal)
   );

   fetch_unit #(.ADDR_W(4), .RESET_PC(4'h0)) dut4 (
      .clk_i(clk), .rstn_i(rstn), .mem_addr_o(mem_addr4), .mem_data_i(mem_data4),
      .redirect_i(redirect4), .redirect_pc_i(redirect_pc4), .valid_o(valid4),
      .ready_i(ready4), .opcode_o(opcode4), .operand_o(operand4), .pc_o(pc4),
      .len_o(len4), .illegal_o(illegal4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memories: data for an address appears the following cycle.
   always @(posedge clk) begin
      mem_data  <= {mem[8'(mem_addr + 8'd2)], mem[8'(mem_addr + 8'd1)], mem[mem_addr]};
      mem_data4 <= {mem4[4'(mem_addr4 + 4'd2)], mem4[4'(mem_addr4 + 4'd1)], mem4[mem_addr4]};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t make_exp(input logic [7:0] a);
      exp_t e;
      logic legal;
      e.op  = mem[a];
      e.opr = {mem[8'(a + 8'd2)], mem[8'(a + 8'd1)]};
      e.pc  = a;
      legal = e.op inside {8'h09, 8'h05, 8'h15, 8'h29, 8'h25, 8'h35, 8'h49, 8'h45, 8'h55};
      e.len = legal ? 2'd2 : 2'd1;
      e.ill = ~legal;
      return e;
   endfunction

   // Monitor: latency model (fetch at k=0, valid from k=2) and instruction scoreboard.
   initial begin
      int         phase;
      logic [7:0] model_pc;
      exp_t       e;
      logic       hs;
      phase    = 0;
      model_pc = 8'h00;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            check("rst_valid", 32'(valid), 32'd0);
            check("rst_addr", 32'(mem_addr), 32'h00);
            check("rst_fields", {opcode, operand, len, illegal}, 32'd0);
            check("rst_pc", 32'(pc), 32'd0);
            phase    = 0;
            model_pc = 8'h00;
            exp_q.delete();
            exp_q.push_back(make_exp(model_pc));
         end else begin
            hs = 1'b0;
            check("valid", 32'(valid), 32'(phase >= 2));
            check("mem_addr", 32'(mem_addr), 32'(model_pc));
            if (valid && exp_q.size() > 0) begin
               e = exp_q[0];
               check("opcode", 32'(opcode), 32'(e.op));
               check("operand", 32'(operand), 32'(e.opr));
               check("pc_o", 32'(pc), 32'(e.pc));
               check("len", 32'(len), 32'(e.len));
               check("illegal", 32'(illegal), 32'(e.ill));
               if (ready) begin
                  void'(exp_q.pop_front());
                  hs = 1'b1;
               end
            end
            if (redirect) begin
               model_pc = redirect_pc;
               exp_q.delete();
               exp_q.push_back(make_exp(model_pc));
               phase = 0;
            end else if (hs) begin
               model_pc = 8'(model_pc + 8'(e.len));
               exp_q.push_back(make_exp(model_pc));
               phase = 0;
            end else if (phase < 2) begin
               phase = phase + 1;
            end
         end
      end
   end

   task automatic wait_valid(input string name);
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (valid) return;
      end
      n_cmp++;
      n_err++;
      $display("FAIL %s: valid_o never rose, required 1 within 30 cycles", name);
   endtask

   // Stimulus: directed scenarios, then random ready/redirect traffic, then 4-bit wrap.
   initial begin
      logic [7:0] legal_ops [9];
      logic       seen;
      legal_ops = '{8'h09, 8'h05, 8'h15, 8'h29, 8'h25, 8'h35, 8'h49, 8'h45, 8'h55};
      rstn = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_pc = 8'h00;
      ready4 = 1'b1; redirect4 = 1'b0; redirect_pc4 = 4'h0;
      for (int i = 0; i < 256; i++)
         mem[i] = ($urandom_range(0, 1) == 0) ? legal_ops[$urandom_range(0, 8)] : 8'($urandom);
      mem[0] = 8'h09; mem[1] = 8'hAA; mem[2] = 8'hBB; mem[3] = 8'h02; mem[4] = 8'hFF;
      mem[8'h10] = 8'h45; mem[8'h11] = 8'h12; mem[8'h12] = 8'h34;
      mem[8'h20] = 8'h55;
      for (int i = 0; i < 16; i++) mem4[i] = 8'hEA;
      mem4[14] = 8'h09; mem4[15] = 8'h5A; mem4[0] = 8'hC3;
      mem_data = 24'h0; mem_data4 = 24'h0;

      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;

      // Back-pressure on the first instruction, then free run through 0xBB/0x02/0xFF.
      wait_valid("first_valid");
      ready = 1'b0;
      repeat (5) @(posedge clk);
      #1 ready = 1'b1;
      repeat (16) @(posedge clk);

      // Redirect while the fetch is in its response cycle.
      wait_valid("pre_resp_redirect");
      @(posedge clk);
      @(posedge clk);
      #1 redirect = 1'b1; redirect_pc = 8'h10;
      @(posedge clk);
      #1 redirect = 1'b0;

      // Redirect coincident with a handshake.
      wait_valid("post_resp_redirect");
      redirect = 1'b1; redirect_pc = 8'h20;
      @(posedge clk);
      #1 redirect = 1'b0;

      // Asynchronous reset while an instruction is held.
      wait_valid("pre_async_reset");
      ready = 1'b0;
      @(posedge clk);
      #3 rstn = 1'b0;
      #1 check("async_valid", 32'(valid), 32'd0);
      check("async_addr", 32'(mem_addr), 32'h00);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1; ready = 1'b1;

      for (int i = 0; i < 600; i++) begin
         @(posedge clk);
         #1;
         ready       = ($urandom_range(0, 3) != 0);
         redirect    = ($urandom_range(0, 15) == 0);
         redirect_pc = 8'($urandom);
      end
      #0 redirect = 1'b0; ready = 1'b1;

      // Wrap-around: 2-byte instruction at 0xE of a 16-entry space.
      @(posedge clk);
      #1 redirect4 = 1'b1; redirect_pc4 = 4'hE;
      @(posedge clk);
      #1 redirect4 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(posedge clk);
         #1 seen = valid4;
      end
      check("wrap_seen", 32'(seen), 32'd1);
      check("wrap_pc", 32'(pc4), 32'hE);
      check("wrap_len", 32'(len4), 32'd2);
      check("wrap_operand", 32'(operand4), 32'hC35A);
      @(posedge clk);
      #1 check("wrap_next_addr", 32'(mem_addr4), 32'h0);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of the 3-byte-read instruction memory (`mem_t`). It owns the program counter and drives the memory read address. It captures the opcode plus two operand bytes returned one cycle later, and classifies the opcode to get the instruction length. It presents the instruction to decode over a valid/ready handshake, and accepts PC redirects from execute.

## Interface
Parameters:
- ADDR_W, default MEM_ADDR_SIZE: PC and memory address width.
- RESET_PC, default 0: PC value loaded on reset.

Ports:
- clk_i, input, 1: clock; all state updates on the rising edge.
- rstn_i, input, 1: asynchronous active-low reset.
- mem_addr_o, input to memory / output here, ADDR_W: read address to memory addr_i; equals the PC register.
- mem_data_i, input, 24: memory data_o, laid out as {byte+2, byte+1, byte+0}; valid the cycle after the address is presented.
- redirect_i, input, 1: load a new PC and discard any in-flight or held instruction.
- redirect_pc_i, input, ADDR_W: target PC, sampled when redirect_i=1.
- valid_o, output, 1: instruction outputs are valid.
- ready_i, input, 1: decode accepts the instruction. A handshake is valid_o & ready_i at a rising edge.
- opcode_o, output, 8: byte+0.
- operand_o, output, 16: {byte+2, byte+1}.
- pc_o, output, ADDR_W: address of opcode_o.
- len_o, output, 2: instruction length in bytes (1 or 2).
- illegal_o, output, 1: opcode not in the supported set.

## Operation
- Supported opcodes are the nes_cpu_pkg constants ORA/AND/EOR in IMM, ZPG and ZPG_X modes (6502 encodings 0x09, 0x05, 0x15, 0x29, 0x25, 0x35, 0x49, 0x45, 0x55).
  - Supported opcodes: len=2, illegal=0.
  - Any other opcode: len=1, illegal=1. It is still delivered, not dropped.
- FSM has three states:
  - S_REQ: mem_addr_o=pc. Go to S_RESP unconditionally.
  - S_RESP: mem_data_i is valid. Register opcode, operand, pc, len and illegal into the output registers. Go to S_VALID.
  - S_VALID: valid_o=1 and the outputs are held stable. On handshake: pc <= pc + len_o, go to S_REQ. Without ready_i: stay in S_VALID.
- PC arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- The memory is read-only from this block. The fetch unit never drives the write enable.
- Redirect has priority over everything in any state. On redirect:
  - pc <= redirect_pc_i;
  - state <= S_REQ;
  - valid_o deasserts the next cycle;
  - any data arriving in S_RESP is discarded.
- Redirect in the same cycle as a handshake: the handshake completes (decode has taken the instruction), but the PC comes from redirect_pc_i and not from pc + len.
- Reset (asynchronous, any state):
  - state = S_REQ, pc = RESET_PC;
  - valid_o = 0, opcode_o = 0, operand_o = 0, pc_o = 0, len_o = 0, illegal_o = 0;
  - mem_addr_o = RESET_PC.

## Timing
- Request at cycle N (S_REQ) → data at the memory output in cycle N+1 (S_RESP) → valid_o=1 from cycle N+2.
- Peak throughput is one instruction per 3 cycles when ready_i is held high.
- The handshake at the end of cycle M causes the next S_REQ in cycle M+1, with mem_addr_o = old pc + len.
- valid_o depends only on state. There is no combinational path from ready_i or redirect_i to valid_o.
- mem_addr_o is a registered output (the PC register).
- Outputs must not change while valid_o=1 && !ready_i, unless a redirect occurs.
- Deasserting rstn_i clears valid_o immediately, without waiting for a clock.

## Test plan
- Reset with RESET_PC=0; memory[0..2] = 0x09, 0xAA, 0xBB; ready_i=1.
  - Required: mem_addr_o=0 during reset and in cycle 0.
  - Required: valid_o rises in cycle 2 with opcode 0x09, operand 0xBBAA, pc 0, len 2, illegal 0.
  - Required: the next mem_addr_o is 2.
- Back-pressure: ready_i=0 for 5 cycles after valid_o rises.
  - Required: outputs stay stable and no new address is issued.
  - Required: when ready_i rises, the handshake occurs and mem_addr_o becomes pc+2 one cycle later.
- Illegal opcode 0xFF at address 4.
  - Required: delivered with len 1, illegal 1.
  - Required: the next fetch address is 5.
- Redirect in S_RESP to 0x10.
  - Required: the captured data is discarded and valid_o stays 0.
  - Required: the next S_REQ drives 0x10, and the delivered pc_o is 0x10.
- Redirect coincident with a handshake, redirect_pc_i=0x20.
  - Required: the next address is 0x20, not pc+len.
- Wrap-around with ADDR_W=4 and pc=0xE holding a 2-byte opcode.
  - Required: the next pc is 0x0.
- Asynchronous reset asserted mid-S_VALID.
  - Required: valid_o drops immediately.
  - Required: after release, fetch restarts at RESET_PC.
